// File: rtl/r_serial_tx.sv
// Asynchronous-serial transmitter: start bit, 8 data bits LSB-first, optional even parity, stop bit.
// Sits downstream of an enabled byte register whose enable is driven by ready.
module r_serial_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] d,
   input  logic       load,
   output logic       ready,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

   state_t      state;
   logic [7:0]  shift;
   logic        par_bit;
   logic [2:0]  bit_idx;
   logic [15:0] cnt;
   logic        bit_end;

   assign bit_end = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         shift   <= 8'd0;
         par_bit <= 1'b0;
         bit_idx <= 3'd0;
         cnt     <= 16'd0;
         txd     <= 1'b1;
         ready   <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (ready && load) begin
                  shift   <= d;
                  par_bit <= ^d;
                  bit_idx <= 3'd0;
                  cnt     <= 16'd0;
                  state   <= START;
                  ready   <= 1'b0;
                  busy    <= 1'b1;
                  txd     <= 1'b0;
               end
            end

            START: begin
               if (bit_end) begin
                  cnt   <= 16'd0;
                  state <= DATA;
                  txd   <= shift[0];
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            // txd always carries the bit that the next bit time will present
            DATA: begin
               if (bit_end) begin
                  cnt   <= 16'd0;
                  shift <= {1'b0, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     if (PARITY_EN) begin
                        state <= PARITY;
                        txd   <= par_bit;
                     end else begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shift[1];
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            PARITY: begin
               if (bit_end) begin
                  cnt   <= 16'd0;
                  state <= STOP;
                  txd   <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            STOP: begin
               if (bit_end) begin
                  cnt   <= 16'd0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  done  <= 1'b1;
                  txd   <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            default: begin
               state <= IDLE;
               txd   <= 1'b1;
               ready <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_r_serial_tx.sv
// Scoreboard bench for r_serial_tx: three lanes (4 clk/bit no parity, 4 clk/bit parity, 1 clk/bit).
// Stimulus pushes expected frames; per-lane monitors pop them when busy rises and compare the line.
module tb_r_serial_tx;

   logic       clk;
   logic       rst   [3];
   logic [7:0] din   [3];
   logic       load  [3];
   logic       ready [3];
   logic       txd   [3];
   logic       busy  [3];
   logic       done  [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         k;
      logic [7:0] b;
      int         e0;
   } exp_t;

   exp_t sb[$];

   r_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
      .clk(clk), .reset(rst[0]), .d(din[0]), .load(load[0]),
      .ready(ready[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));

   r_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
      .clk(clk), .reset(rst[1]), .d(din[1]), .load(load[1]),
      .ready(ready[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));

   r_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) dut2 (
      .clk(clk), .reset(rst[2]), .d(din[2]), .load(load[2]),
      .ready(ready[2]), .txd(txd[2]), .busy(busy[2]), .done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1);
   end

   function automatic int cpb_of(input int k);
      return (k == 2) ? 1 : 4;
   endfunction

   function automatic bit par_of(input int k);
      return (k == 1);
   endfunction

   // Line level for each bit slot of a frame; slots past the stop bit stay high.
   function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit p);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i + 1] = b[i];
      if (p) f[9] = (($countones(b) % 2) == 1);
      return f;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   task automatic monitor(input int k);
      int          c;
      int          n;
      int          idx;
      logic [10:0] bits;
      exp_t        item;
      logic        prev_busy;
      bit          aborted;
      c = cpb_of(k);
      n = (par_of(k) ? 11 : 10) * c;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busy[k] === 1'b1 && prev_busy == 1'b0) begin
            prev_busy = 1'b1;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
               if (idx < 0 && sb[i].k == k) idx = i;
            if (idx < 0) begin
               check($sformatf("unexpected_frame_lane%0d", k), 32'(busy[k]), 32'd0);
            end else begin
               item = sb[idx];
               sb.delete(idx);
               bits = frame_bits(item.b, par_of(k));
               check($sformatf("start_cycle_lane%0d", k), 32'(cyc), 32'(item.e0));
               aborted = 1'b0;
               for (int t = 0; t < n; t++) begin
                  if (t > 0) @(negedge clk);
                  check($sformatf("txd_lane%0d_byte%02h_t%0d", k, item.b, t),
                        32'(txd[k]), 32'(bits[t / c]));
                  check($sformatf("busy_ready_done_lane%0d_t%0d", k, t),
                        32'({busy[k], ready[k], done[k]}), 32'(3'b100));
                  if (rst[k] === 1'b1) begin
                     aborted = 1'b1;
                     break;
                  end
               end
               @(negedge clk);
               if (aborted)
                  check($sformatf("reset_abort_lane%0d", k),
                        32'({txd[k], ready[k], busy[k], done[k]}), 32'(4'b1100));
               else
                  check($sformatf("done_cycle_lane%0d", k),
                        32'({txd[k], ready[k], busy[k], done[k]}), 32'(4'b1101));
               prev_busy = busy[k];
            end
         end else if (busy[k] === 1'b0) begin
            prev_busy = 1'b0;
            check($sformatf("idle_lane%0d", k),
                  32'({txd[k], ready[k], busy[k], done[k]}), 32'(4'b1100));
         end
      end
   endtask

   task automatic send(input int k, input logic [7:0] b);
      int g = 0;
      @(negedge clk);
      while (ready[k] !== 1'b1) begin
         @(negedge clk);
         g++;
         if (g > 2000) begin
            check($sformatf("send_ready_timeout_lane%0d", k), 32'(ready[k]), 32'd1);
            return;
         end
      end
      din[k]  = b;
      load[k] = 1'b1;
      @(posedge clk);
      #1 load[k] = 1'b0;
      sb.push_back('{k, b, cyc});
      din[k] = 8'($urandom);
   endtask

   task automatic wait_idle(input int k);
      int g = 0;
      @(negedge clk);
      while (!(ready[k] === 1'b1 && busy[k] === 1'b0)) begin
         @(negedge clk);
         g++;
         if (g > 2000) begin
            check($sformatf("idle_timeout_lane%0d", k), 32'(ready[k]), 32'd1);
            return;
         end
      end
   endtask

   task automatic random_frames(input int k, input int count);
      for (int i = 0; i < count; i++) begin
         repeat ($urandom_range(0, 6)) @(posedge clk);
         send(k, 8'($urandom));
      end
      wait_idle(k);
   endtask

   task automatic lane0;
      int e0;
      send(0, 8'hA5);
      wait_idle(0);
      // load pulse with a different byte while the frame is in flight must be ignored
      send(0, 8'h3C);
      e0 = cyc;
      repeat (9) @(posedge clk);
      #1;
      din[0]  = 8'hFF;
      load[0] = 1'b1;
      @(posedge clk);
      #1 load[0] = 1'b0;
      check("ignored_load_not_counted", 32'(cyc - e0), 32'd10);
      wait_idle(0);
      repeat (30) @(posedge clk);
      random_frames(0, 8);
   endtask

   task automatic lane1;
      send(1, 8'h07);
      wait_idle(1);
      send(1, 8'hA5);
      wait_idle(1);
      // reset during data bit 3 (slots 16..19 of the frame)
      send(1, 8'hC3);
      repeat (17) @(posedge clk);
      #1 rst[1] = 1'b1;
      @(posedge clk);
      #1 rst[1] = 1'b0;
      repeat (10) @(posedge clk);
      send(1, 8'h81);
      wait_idle(1);
      random_frames(1, 8);
   endtask

   task automatic lane2;
      int e0;
      int g = 0;
      @(negedge clk);
      while (ready[2] !== 1'b1 && g < 2000) begin
         @(negedge clk);
         g++;
      end
      din[2]  = 8'h55;
      load[2] = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      sb.push_back('{2, 8'h55, e0});
      sb.push_back('{2, 8'hAA, e0 + 11});
      din[2] = 8'hAA;
      repeat (11) @(posedge clk);
      #1 load[2] = 1'b0;
      din[2] = 8'h00;
      wait_idle(2);
      random_frames(2, 10);
   endtask

   initial begin
      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         load[k] = 1'b0;
         din[k]  = 8'h00;
         rst[k]  = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         check($sformatf("reset_state_lane%0d", k),
               32'({txd[k], ready[k], busy[k], done[k]}), 32'(4'b1100));
      repeat (20) @(posedge clk);
      fork
         lane0();
         lane1();
         lane2();
      join
      repeat (20) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
